// File: rtl/clkdiv_pkg.sv
// Shared mode encodings and width helper for the programmable clock divider.
package clkdiv_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Index width for n items, never narrower than one bit
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: divisor/mode config, terminal counter, tick strobe and divided clock.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             run,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             tick,
    output logic             clk_out
);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic             term_c;

    always_comb begin
        div_d     = div_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;
        term_c    = (cnt_q == div_q - CNT_W'(1));

        if (wr) begin
            div_d  = wr_div;
            mode_d = wr_mode;
            cnt_d  = '0;
        end

        // A write on this edge suppresses counting, so it also beats a terminal count
        if (sync) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (!wr && run && adv && (div_q != '0)) begin
            if (term_c) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                clk_out_d = ~clk_out_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Pulse mode mirrors the strobe exactly, including while paused
        if (mode_d == MODE_PULSE) begin
            clk_out_d = tick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= CNT_W'(DEFAULT_DIV);
            mode_q    <= MODE_TOGGLE;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock-enable generator: write decode, cfg_err, sync fan-out.
// Optional shared prescaler enabled by defining CLKDIV_PRESCALE_EN.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    parameter int unsigned PRESCALE    = 100
) (
    input  logic                      clk,
    input  logic                      resetSW,
    input  logic [NUM_CH-1:0]         run,
    input  logic                      sync,
    input  logic                      wr_en,
    input  logic [ch_w(NUM_CH)-1:0]   wr_ch,
    input  logic [CNT_W-1:0]          wr_div,
    input  logic                      wr_mode,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         clk_out,
    output logic                      cfg_err
);

    if (NUM_CH < 1 || NUM_CH > 16 || PRESCALE < 1) begin : g_param_chk
        $error("prog_clock_divider: NUM_CH must be 1..16 and PRESCALE at least 1");
    end

    logic              wr_valid_c;
    logic [NUM_CH-1:0] wr_sel_c;
    logic              adv_c;
    logic              cfg_err_q, cfg_err_d;

    always_comb begin
        wr_valid_c = (32'(wr_ch) < NUM_CH);
        cfg_err_d  = wr_en && !wr_valid_c;
        wr_sel_c   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_sel_c[i] = wr_en && wr_valid_c && (32'(wr_ch) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (resetSW) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

`ifdef CLKDIV_PRESCALE_EN
    localparam int unsigned PRE_W = ch_w(PRESCALE);

    logic [PRE_W-1:0] pre_q, pre_d;

    // Free-running prescaler; its last count is the shared advance strobe
    always_comb begin
        adv_c = (pre_q == PRE_W'(PRESCALE - 1));
        pre_d = (sync || adv_c) ? '0 : pre_q + PRE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (resetSW) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign adv_c = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (resetSW),
            .adv     (adv_c),
            .run     (run[g]),
            .sync    (sync),
            .wr      (wr_sel_c[g]),
            .wr_div  (wr_div),
            .wr_mode (wr_mode),
            .tick    (tick[g]),
            .clk_out (clk_out[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider; behavioural model predicts every cycle's outputs.
module tb_prog_clock_divider;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned DDIV = 6;
    localparam int unsigned PRE  = 10;

    logic           clk = 1'b0;
    logic           rst_sw;
    logic [NCH-1:0] run;
    logic           sync;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [CW-1:0]  wr_div;
    logic           wr_mode;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
    logic           cfg_err;

    logic [2:0]     run2;
    logic           sync2;
    logic           wr_en2;
    logic [1:0]     wr_ch2;
    logic [CW-1:0]  wr_div2;
    logic           wr_mode2;
    logic [2:0]     tick2;
    logic [2:0]     clk_out2;
    logic           cfg_err2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_clock_divider #(
        .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV), .PRESCALE(PRE)
    ) dut (
        .clk(clk), .resetSW(rst_sw), .run(run), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
        .tick(tick), .clk_out(clk_out), .cfg_err(cfg_err)
    );

    // Three-channel instance so that an out-of-range channel index is representable
    prog_clock_divider #(
        .NUM_CH(3), .CNT_W(CW), .DEFAULT_DIV(DDIV), .PRESCALE(PRE)
    ) dut3 (
        .clk(clk), .resetSW(rst_sw), .run(run2), .sync(sync2), .wr_en(wr_en2),
        .wr_ch(wr_ch2), .wr_div(wr_div2), .wr_mode(wr_mode2),
        .tick(tick2), .clk_out(clk_out2), .cfg_err(cfg_err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int   m_div [NCH];
    int   m_cnt [NCH];
    bit   m_mode[NCH];
    bit   m_clk [NCH];
    bit   m_tick[NCH];
    bit   m_cfg;
    int   m_pre;

    logic [8:0] exp_q[$];
    string      phase;
    int         tcnt [NCH];
    int         tcnt2[3];

    task automatic model_step();
        bit adv;
        bit w;
        logic [8:0] e;
`ifdef CLKDIV_PRESCALE_EN
        adv = (m_pre == PRE - 1);
`else
        adv = 1'b1;
`endif
        if (rst_sw) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = DDIV; m_cnt[c] = 0; m_mode[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            end
            m_cfg = 0;
            m_pre = 0;
        end else begin
            m_cfg = wr_en && (int'(wr_ch) >= NCH);
            for (int c = 0; c < NCH; c++) begin
                w = wr_en && (int'(wr_ch) == c);
                m_tick[c] = 0;
                if (w) begin
                    m_div[c]  = int'(wr_div);
                    m_mode[c] = wr_mode;
                    m_cnt[c]  = 0;
                end
                if (sync) begin
                    m_cnt[c] = 0;
                    m_clk[c] = 0;
                end else if (!w && run[c] && adv && m_div[c] != 0) begin
                    m_cnt[c]++;
                    if (m_cnt[c] == m_div[c]) begin
                        m_cnt[c]  = 0;
                        m_tick[c] = 1;
                        if (!m_mode[c]) m_clk[c] = !m_clk[c];
                    end
                end
                if (m_mode[c]) m_clk[c] = m_tick[c];
            end
            m_pre = sync ? 0 : (m_pre + 1) % PRE;
        end
        e[8] = m_cfg;
        for (int c = 0; c < NCH; c++) begin
            e[c]     = m_tick[c];
            e[4 + c] = m_clk[c];
        end
        exp_q.push_back(e);
    endtask

    // Inputs are already applied; predict, clock once, then compare away from the edge
    task automatic step();
        logic [8:0] e;
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({phase, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(phase, 32'({cfg_err, clk_out, tick}), 32'(e));
        end
        for (int c = 0; c < NCH; c++) tcnt[c] += int'(tick[c]);
        for (int c = 0; c < 3; c++) tcnt2[c] += int'(tick2[c]);
    endtask

    task automatic run_n(input int n);
        repeat (n) step();
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < NCH; c++) tcnt[c] = 0;
        for (int c = 0; c < 3; c++) tcnt2[c] = 0;
    endtask

    task automatic wr(input int ch, input int d, input bit m);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_div  = 8'(d);
        wr_mode = m;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_sw = 1'b1; run = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
        run2 = '0; sync2 = 1'b0; wr_en2 = 1'b0; wr_ch2 = '0; wr_div2 = '0; wr_mode2 = 1'b0;
        clr_cnt();

        phase = "reset";
        run_n(2);
        rst_sw = 1'b0;

        phase = "default_div";
        run = 4'b0001;
        clr_cnt();
        run_n(12);
`ifndef CLKDIV_PRESCALE_EN
        check("default_div_ticks", 32'(tcnt[0]), 32'd2);
`endif

        phase = "ch0_d4";
        wr(0, 4, 1'b0);
        clr_cnt();
        run_n(40);
`ifndef CLKDIV_PRESCALE_EN
        check("ch0_d4_ticks", 32'(tcnt[0]), 32'd10);
`endif
        check("ch0_only_ticks", 32'(tcnt[1] + tcnt[2] + tcnt[3]), 32'd0);

        phase = "ch1_pulse_pause";
        wr(1, 3, 1'b1);
        run = 4'b0011;
        run_n(7);
        run = 4'b0001;
        run_n(5);
        run = 4'b0011;
        clr_cnt();
        run_n(12);
`ifndef CLKDIV_PRESCALE_EN
        check("ch1_resume_ticks", 32'(tcnt[1]), 32'd4);
`endif

        phase = "ch2_write_at_tc";
        wr(2, 4, 1'b0);
        run = 4'b0111;
        run_n(3);
        wr(2, 4, 1'b0);
        clr_cnt();
        run_n(4);
`ifndef CLKDIV_PRESCALE_EN
        check("ch2_tick_after_rewrite", 32'(tcnt[2]), 32'd1);
`endif

        phase = "ch3_d0";
        wr(3, 0, 1'b0);
        run = 4'b1111;
        clr_cnt();
        run_n(20);
        check("ch3_d0_ticks", 32'(tcnt[3]), 32'd0);

        phase = "ch3_d1";
        wr(3, 1, 1'b0);
        clr_cnt();
        run_n(10);
`ifndef CLKDIV_PRESCALE_EN
        check("ch3_d1_ticks", 32'(tcnt[3]), 32'd10);
`endif

        phase = "sync_align";
        run = 4'b0000;
        wr(0, 5, 1'b0);
        wr(1, 7, 1'b0);
        run = 4'b0011;
        run_n(9);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_clk_out_cleared", 32'(clk_out[1:0]), 32'd0);
        clr_cnt();
        run_n(14);
`ifndef CLKDIV_PRESCALE_EN
        check("sync_ch0_ticks", 32'(tcnt[0]), 32'd2);
        check("sync_ch1_ticks", 32'(tcnt[1]), 32'd2);
`endif

        phase = "prescale_d3";
        run = 4'b0001;
        wr(0, 3, 1'b0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        clr_cnt();
        run_n(60);
`ifdef CLKDIV_PRESCALE_EN
        check("prescale_d3_ticks", 32'(tcnt[0]), 32'd2);
`else
        check("prescale_d3_ticks", 32'(tcnt[0]), 32'd20);
`endif

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            run     = 4'($urandom);
            sync    = ($urandom_range(0, 19) == 0);
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_div  = 8'($urandom_range(0, 5));
            wr_mode = 1'($urandom_range(0, 1));
            step();
        end
        run = '0; sync = 1'b0; wr_en = 1'b0;

        phase = "cfg_err";
        wr_en2 = 1'b1; wr_ch2 = 2'd1; wr_div2 = 8'd2; wr_mode2 = 1'b1;
        run2 = 3'b010;
        step();
        check("cfg_err_valid_write", 32'(cfg_err2), 32'd0);
        wr_ch2 = 2'd3; wr_div2 = 8'd9; wr_mode2 = 1'b0;
        clr_cnt();
        step();
        check("cfg_err_pulse", 32'(cfg_err2), 32'd1);
        wr_en2 = 1'b0;
        step();
        check("cfg_err_one_cycle", 32'(cfg_err2), 32'd0);
        run_n(8);
`ifndef CLKDIV_PRESCALE_EN
        check("cfg_err_config_kept", 32'(tcnt2[1]), 32'd5);
`endif
        check("cfg_err_other_ch_quiet", 32'(tcnt2[0] + tcnt2[2]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
